des_decrypt_iter: RTL and testbench

//  Iterative DES decryptor: accepts one 64-bit ciphertext block plus 64-bit key over a valid/ready

---
 rtl/des_pkg.sv | 183 ++++++++++++++++++
 rtl/des_feistel_f.sv | 26 ++
 rtl/des_decrypt_iter.sv | 131 +++++++++++++
 tb/tb_des_decrypt_iter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES constants shared by the iterative decryptor: widths, FSM state codes,
// permutation / S-box tables, the reverse key rotation schedule and the
// table-driven permutation helpers (init_perm / final_perm and friends).
// Table entries use DES numbering (1 = MSB), so DES bit n of a W-bit vector
// lives at index W-n.
package des_pkg;

    localparam int BLOCK_W     = 64;
    localparam int HALF_W      = 32;
    localparam int CD_W        = 56;
    localparam int SUBKEY_W    = 48;
    localparam int ROUND_CNT_W = 4;
    localparam int LAST_ROUND  = 15;

    typedef logic [1:0] state_t;
    localparam state_t STATE_IDLE  = 2'd0;
    localparam state_t STATE_ROUND = 2'd1;
    localparam state_t STATE_DONE  = 2'd2;

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TABLE [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Right-rotation applied to C and D before each decryption round;
    // entry 0 is zero because round 0 uses PC2(PC1(key)) = K16 directly.
    localparam int RSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S-boxes indexed by {b1, b6, b2..b5} of each 6-bit group.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] init_perm(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int i = 0; i < 64; i++) dout[6'(63 - i)] = din[6'(64 - IP_TABLE[i])];
        return dout;
    endfunction

    function automatic logic [63:0] final_perm(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int i = 0; i < 64; i++) dout[6'(63 - i)] = din[6'(64 - FP_TABLE[i])];
        return dout;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] din);
        logic [47:0] dout;
        dout = '0;
        for (int i = 0; i < 48; i++) dout[6'(47 - i)] = din[5'(32 - E_TABLE[i])];
        return dout;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] din);
        logic [31:0] dout;
        dout = '0;
        for (int i = 0; i < 32; i++) dout[5'(31 - i)] = din[5'(32 - P_TABLE[i])];
        return dout;
    endfunction

    // Parity bits (DES bits 8,16..64) are simply never selected here.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] dout;
        dout = '0;
        for (int i = 0; i < 56; i++) dout[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
        return dout;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] dout;
        dout = '0;
        for (int i = 0; i < 48; i++) dout[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
        return dout;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] half, input logic [1:0] amount);
        logic [27:0] dout;
        case (amount)
            2'd1:    dout = {half[0], half[27:1]};
            2'd2:    dout = {half[1:0], half[27:2]};
            default: dout = half;
        endcase
        return dout;
    endfunction

    // True when every key byte carries odd parity.
    function automatic logic key_parity_odd(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) ok = ok & (^key[6'(8 * i) +: 8]);
        return ok;
    endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R, K): expand R to 48 bits, mix in the round key,
// squeeze through the eight S-boxes and apply the P permutation.
// Purely combinational.
module des_feistel_f
    import des_pkg::*;
(
    input  logic [SUBKEY_W-1:0] round_key,
    input  logic [HALF_W-1:0]   r_half,
    output logic [HALF_W-1:0]   f_out
);

    logic [SUBKEY_W-1:0] mixed;
    logic [HALF_W-1:0]   sbox_out;

    assign mixed = expand(r_half) ^ round_key;

    // One S-box lookup per 6-bit group; S1 takes the most significant group.
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        logic [5:0] chunk;
        assign chunk = mixed[47 - 6 * g -: 6];
        assign sbox_out[31 - 4 * g -: 4] = 4'(SBOX[g][{chunk[5], chunk[0], chunk[4:1]}]);
    end

    assign f_out = p_perm(sbox_out);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, round keys derived
// on the fly by rotating C/D to the right (K16 first, K1 last).
// Optional feature macro: DES_KEY_PARITY_CHECK_EN -- when defined, a key with
// any even-parity byte skips the rounds and returns plain_text=0, key_err=1.
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  cipher_text,
    input  logic [BLOCK_W-1:0]  cipher_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  plain_text,
    output logic                key_err,
    output logic                busy
);

    state_t                 state;
    logic [ROUND_CNT_W-1:0] round_cnt;
    logic [HALF_W-1:0]      l_reg;
    logic [HALF_W-1:0]      r_reg;
    logic [CD_W-1:0]        cd_reg;
    logic [BLOCK_W-1:0]     plain_text_q;
    logic                   out_valid_q;

    logic                   accept;
    logic                   skip_rounds;
    logic                   finish_block;
    logic [1:0]             shift_amt;
    logic [CD_W-1:0]        cd_rot;
    logic [SUBKEY_W-1:0]    round_key;
    logic [HALF_W-1:0]      f_out;
    logic [BLOCK_W-1:0]     fp_block;

    assign in_ready = (state == STATE_IDLE);
    assign busy     = (state != STATE_IDLE);
    assign accept   = in_valid && in_ready;

    // The rotation for this round is applied before PC2, so the key used in
    // round i is already K(16-i); cd_reg then keeps the rotated value.
    assign shift_amt = 2'(RSHIFT[round_cnt]);
    assign cd_rot    = {rotr28(cd_reg[55:28], shift_amt), rotr28(cd_reg[27:0], shift_amt)};
    assign round_key = pc2(cd_rot);

    des_feistel_f u_feistel (
        .round_key (round_key),
        .r_half    (r_reg),
        .f_out     (f_out)
    );

    // Output of the last round with the halves swapped: {R16, L16}.
    assign fp_block = final_perm({l_reg ^ f_out, r_reg});

    assign finish_block = (state == STATE_ROUND) &&
                          (skip_rounds || (round_cnt == ROUND_CNT_W'(LAST_ROUND)));

`ifdef DES_KEY_PARITY_CHECK_EN
    logic parity_fail;
    logic key_err_q;

    // Capture the parity verdict at accept and publish it alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_fail <= 1'b0;
            key_err_q   <= 1'b0;
        end else if (accept) begin
            parity_fail <= ~key_parity_odd(cipher_key);
        end else if (finish_block) begin
            key_err_q   <= parity_fail;
        end
    end

    assign skip_rounds = parity_fail;
    assign key_err     = key_err_q;
`else
    assign skip_rounds = 1'b0;
    assign key_err     = 1'b0;
`endif

    // Main FSM: load on accept, run 16 rounds, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STATE_IDLE;
            round_cnt    <= '0;
            l_reg        <= '0;
            r_reg        <= '0;
            cd_reg       <= '0;
            plain_text_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (accept) begin
                        {l_reg, r_reg} <= init_perm(cipher_text);
                        cd_reg         <= pc1(cipher_key);
                        round_cnt      <= '0;
                        state          <= STATE_ROUND;
                    end
                end
                STATE_ROUND: begin
                    l_reg  <= r_reg;
                    r_reg  <= l_reg ^ f_out;
                    cd_reg <= cd_rot;
                    if (finish_block) begin
                        plain_text_q <= skip_rounds ? '0 : fp_block;
                        out_valid_q  <= 1'b1;
                        state        <= STATE_DONE;
                    end else begin
                        round_cnt <= round_cnt + ROUND_CNT_W'(1);
                    end
                end
                STATE_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign plain_text = plain_text_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Testbench for des_decrypt_iter: known-answer DES vectors applied from a
// table, a randomly-gapped stream over the same table, and hand-written
// sequences for output back-pressure, mid-block reset and the key parity
// option (DES_KEY_PARITY_CHECK_EN).
module tb_des_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher_text;
    logic [63:0] cipher_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_text;
    logic        key_err;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    localparam int NUM_VECS = 9;
    vec_t vecs [NUM_VECS];

    des_decrypt_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cipher_text (cipher_text),
        .cipher_key  (cipher_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plain_text  (plain_text),
        .key_err     (key_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one block after idle_gap cycles and return just after the accept edge.
    task automatic applyStimulus(input logic [63:0] key, input logic [63:0] ct, input int idle_gap);
        int bound;
        in_valid = 1'b0;
        repeat (idle_gap) cycle();
        cipher_key  = key;
        cipher_text = ct;
        in_valid    = 1'b1;
        bound = 0;
        while (in_ready !== 1'b1 && bound < 50) begin
            cycle();
            bound++;
        end
        if (bound >= 50) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        cycle();
        in_valid    = 1'b0;
        cipher_text = {$urandom, $urandom};
        cipher_key  = {$urandom, $urandom};
    endtask

    // Count cycles from accept until out_valid, optionally poking in_valid with junk.
    task automatic waitResult(input logic junk, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (junk) begin
                in_valid    = 1'($urandom_range(0, 1));
                cipher_text = {$urandom, $urandom};
                cipher_key  = {$urandom, $urandom};
            end
            cycle();
            lat++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) checkOutput("result_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drainResult();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic runVector(input string name, input vec_t v, input int gap, input int hold, input logic junk);
        int lat;
        applyStimulus(v.key, v.ct, gap);
        waitResult(junk, lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'd16);
        checkOutput({name, "_pt"}, plain_text, v.pt);
        checkOutput({name, "_key_err"}, 64'(key_err), 64'd0);
        repeat (hold) cycle();
        checkOutput({name, "_pt_held"}, plain_text, v.pt);
        checkOutput({name, "_valid_held"}, 64'(out_valid), 64'd1);
        drainResult();
        checkOutput({name, "_idle_after"}, 64'({busy, out_valid, in_ready}), 64'b001);
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] held;

        vecs[0] = '{key: 64'h133457799BBCDFF1, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF};
        vecs[1] = '{key: 64'h0E329232EA6D0D73, ct: 64'h0000000000000000, pt: 64'h8787878787878787};
        vecs[2] = '{key: 64'hECCBA8866443200E, ct: 64'h7A17ECABF0F54BFA, pt: 64'hFEDCBA9876543210};
        vecs[3] = '{key: 64'hF1CD6DCD1592F28C, ct: 64'hFFFFFFFFFFFFFFFF, pt: 64'h7878787878787878};
        vecs[4] = '{key: 64'h0101010101010101, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};
        vecs[5] = '{key: 64'hFEFEFEFEFEFEFEFE, ct: 64'h7359B2163E4EDC58, pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[6] = '{key: 64'h0101010101010101, ct: 64'h95F8A5E5DD31D900, pt: 64'h8000000000000000};
        vecs[7] = '{key: 64'hFEFEFEFEFEFEFEFE, ct: 64'h6A075A1A22CE26FF, pt: 64'h7FFFFFFFFFFFFFFF};
        vecs[8] = '{key: 64'h0123456789ABCDEF, ct: 64'h3FA40E8A984D4815, pt: 64'h4E6F772069732074};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        cipher_text = '0;
        cipher_key  = '0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_plain_text", plain_text, 64'd0);
        checkOutput("reset_key_err", 64'(key_err), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        $display("[TB] known-answer table");
        for (int i = 0; i < NUM_VECS; i++) begin
            runVector($sformatf("kat%0d", i), vecs[i], 0, 0, 1'b0);
        end

        $display("[TB] back-pressure with in_valid during DONE");
        applyStimulus(vecs[0].key, vecs[0].ct, 1);
        waitResult(1'b0, lat);
        checkOutput("bp_latency", 64'(lat), 64'd16);
        held        = plain_text;
        cipher_key  = vecs[1].key;
        cipher_text = vecs[1].ct;
        in_valid    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            checkOutput($sformatf("bp_hold%0d", c),
                        {plain_text[61:0], out_valid, in_ready}, {held[61:0], 1'b1, 1'b0});
        end
        checkOutput("bp_pt", plain_text, 64'h0123456789ABCDEF);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp_release_state", 64'({busy, out_valid, in_ready}), 64'b001);
        checkOutput("bp_release_pt_kept", plain_text, 64'h0123456789ABCDEF);
        cycle();
        checkOutput("bp_no_accept_on_handshake", 64'(busy), 64'd0);

        $display("[TB] reset during round 7");
        applyStimulus(vecs[0].key, vecs[0].ct, 0);
        repeat (7) cycle();
        checkOutput("mid_busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_outputs",
                    64'({in_ready, out_valid, key_err, busy}), 64'b1000);
        checkOutput("mid_reset_plain_text", plain_text, 64'd0);
        cycle();
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (out_valid === 1'b1) seen++;
        end
        checkOutput("mid_reset_no_output", 64'(seen), 64'd0);
        runVector("after_reset", vecs[1], 0, 2, 1'b0);

`ifdef DES_KEY_PARITY_CHECK_EN
        $display("[TB] key parity failure");
        applyStimulus(64'h133457799BBCDFF0, 64'h85E813540F0AB405, 0);
        waitResult(1'b0, lat);
        checkOutput("parity_latency", 64'(lat), 64'd1);
        checkOutput("parity_key_err", 64'(key_err), 64'd1);
        checkOutput("parity_pt", plain_text, 64'd0);
        drainResult();
        runVector("parity_recover", vecs[0], 0, 0, 1'b0);
`else
        $display("[TB] parity bit dropped by PC1");
        runVector("parity_ignored",
                  '{key: 64'h133457799BBCDFF0, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF},
                  0, 0, 1'b0);
`endif

        $display("[TB] gapped stream");
        for (int t = 0; t < 30; t++) begin
            int idx;
            idx = int'($urandom_range(0, NUM_VECS - 1));
            runVector($sformatf("stream%0d_v%0d", t, idx), vecs[idx],
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
